// File: rtl/lifo_drain_if.sv
// Handshake and output-stream bundle for lifo_drain.
// Macro LIFO_DRAIN_PARITY_EN adds the out_parity signal.
interface lifo_drain_if #(
    parameter int WIDTH     = 8,
    parameter int PACK      = 4,
    parameter int CNT_WIDTH = 4
) ();
    logic                   rx_rdy;
    logic [WIDTH-1:0]       in_data;
    logic                   rx_done;
    logic                   flush;
    logic [WIDTH*PACK-1:0]  out_word;
    logic [CNT_WIDTH-1:0]   out_count;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
`ifdef LIFO_DRAIN_PARITY_EN
    logic                   out_parity;
`endif

    // Stack side plus downstream consumer drive the block through this view.
    modport master (
        output rx_rdy, in_data, flush, out_ready,
`ifdef LIFO_DRAIN_PARITY_EN
        input  out_parity,
`endif
        input  rx_done, out_word, out_count, out_valid, busy
    );

    modport slave (
        input  rx_rdy, in_data, flush, out_ready,
`ifdef LIFO_DRAIN_PARITY_EN
        output out_parity,
`endif
        output rx_done, out_word, out_count, out_valid, busy
    );
endinterface

// File: rtl/lifo_drain.sv
// Stack drain: four-phase rx_rdy/rx_done pop, PACK-word packing, flushable partial words.
// Macro LIFO_DRAIN_PARITY_EN adds registered even parity (out_parity) over out_word.
module lifo_drain #(
    parameter int WIDTH     = 8,
    parameter int PACK      = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    lifo_drain_if.slave   bus
);
    localparam int OW = WIDTH * PACK;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [OW-1:0]         asm_q, asm_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  rx_done_q, rx_done_d;
    logic                  out_valid_q, out_valid_d;
    logic [OW-1:0]         out_word_q, out_word_d;
    logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
    logic                  busy_q, busy_d;
`ifdef LIFO_DRAIN_PARITY_EN
    logic                  out_parity_q, out_parity_d;
`endif

    logic                  out_free_s;
    logic                  room_s;
    logic                  last_lane_s;
    logic [OW-1:0]         full_word_s;

    function automatic logic even_parity(input logic [OW-1:0] word);
        return ^word;
    endfunction

    // Next-state computation for the handshake FSM, lane assembly and output register.
    always_comb begin
        out_free_s  = !out_valid_q || bus.out_ready;
        room_s      = (idx_q < CNT_WIDTH'(PACK - 1)) || out_free_s;
        last_lane_s = (idx_q == CNT_WIDTH'(PACK - 1));
        full_word_s = asm_q;
        full_word_s[OW-1 -: WIDTH] = bus.in_data;

        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        rx_done_d    = rx_done_q;
        out_word_d   = out_word_q;
        out_count_d  = out_count_q;
        flush_pend_d = flush_pend_q | bus.flush;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A latched flush takes priority over a waiting pop.
                if (flush_pend_q) begin
                    if (idx_q == {CNT_WIDTH{1'b0}}) begin
                        flush_pend_d = bus.flush;
                    end else if (out_free_s) begin
                        out_word_d   = asm_q;
                        out_count_d  = idx_q;
                        out_valid_d  = 1'b1;
                        idx_d        = {CNT_WIDTH{1'b0}};
                        asm_d        = {OW{1'b0}};
                        flush_pend_d = bus.flush;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end else if (bus.rx_rdy && room_s) begin
                    rx_done_d = 1'b1;
                    state_d   = ST_ACK;
                    if (last_lane_s) begin
                        out_word_d  = full_word_s;
                        out_count_d = CNT_WIDTH'(PACK);
                        out_valid_d = 1'b1;
                        idx_d       = {CNT_WIDTH{1'b0}};
                        asm_d       = {OW{1'b0}};
                    end else begin
                        for (int i = 0; i < PACK - 1; i++) begin
                            if (idx_q == CNT_WIDTH'(i)) begin
                                asm_d[i*WIDTH +: WIDTH] = bus.in_data;
                            end else begin
                                asm_d[i*WIDTH +: WIDTH] = asm_q[i*WIDTH +: WIDTH];
                            end
                        end
                        idx_d = idx_q + CNT_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!bus.rx_rdy) begin
                    rx_done_d = 1'b0;
                    state_d   = ST_REL;
                end else begin
                    rx_done_d = 1'b1;
                end
            end
            ST_REL: begin
                // One dead cycle so the stack observes rx_done low before re-offering.
                rx_done_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                rx_done_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (idx_d != {CNT_WIDTH{1'b0}}) || (state_d != ST_IDLE);
`ifdef LIFO_DRAIN_PARITY_EN
        out_parity_d = even_parity(out_word_d);
`endif
    end

    // State and registered outputs; reset discards partial lanes and pending flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= {CNT_WIDTH{1'b0}};
            asm_q        <= {OW{1'b0}};
            flush_pend_q <= 1'b0;
            rx_done_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= {OW{1'b0}};
            out_count_q  <= {CNT_WIDTH{1'b0}};
            busy_q       <= 1'b0;
`ifdef LIFO_DRAIN_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
            rx_done_q    <= rx_done_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_count_q  <= out_count_d;
            busy_q       <= busy_d;
`ifdef LIFO_DRAIN_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign bus.rx_done   = rx_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_count = out_count_q;
    assign bus.busy      = busy_q;
`ifdef LIFO_DRAIN_PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_lifo_drain.sv
// Self-checking bench for lifo_drain: scenario tasks plus a scoreboard on the output stream.
module tb_lifo_drain;
    localparam int WIDTH = 8;
    localparam int PACK  = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [WIDTH*PACK-1:0] word;
        logic [CW-1:0]         count;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    lifo_drain_if #(.WIDTH(WIDTH), .PACK(PACK), .CNT_WIDTH(CW)) bus ();

    lifo_drain #(.WIDTH(WIDTH), .PACK(PACK), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted output word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got word=%h count=%0d, expected no output", bus.out_word, bus.out_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.out_word !== e.word || bus.out_count !== e.count) begin
                    errors++;
                    $display("FAIL sb_word got word=%h count=%0d, expected word=%h count=%0d",
                             bus.out_word, bus.out_count, e.word, e.count);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] d);
        int n = 0;
        bus.in_data = d;
        bus.rx_rdy  = 1'b1;
        while (bus.rx_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.rx_done !== 1'b1) begin
            errors++;
            $display("FAIL offer_timeout data=%h rx_done=%b, expected 1", d, bus.rx_done);
        end
    endtask

    task automatic release_rx();
        int n = 0;
        bus.rx_rdy = 1'b0;
        while (bus.rx_done !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.rx_done !== 1'b0) begin
            errors++;
            $display("FAIL release_timeout rx_done=%b, expected 0", bus.rx_done);
        end
    endtask

    task automatic pop(input logic [WIDTH-1:0] d);
        offer(d);
        release_rx();
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.rx_rdy    = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.rx_done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_word !== 32'h0 || bus.out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_values got rx_done=%b valid=%b busy=%b word=%h count=%0d, expected all 0",
                     bus.rx_done, bus.out_valid, bus.busy, bus.out_word, bus.out_count);
        end
        step();
        step();
        rst = 1'b0;
        // Leave a full word pending plus partial lanes, then reset mid-ACK.
        pop(8'hE0); pop(8'hE1); pop(8'hE2); pop(8'hE3);
        pop(8'h99);
        offer(8'hBB);
        rst = 1'b1;
        bus.rx_rdy = 1'b0;
        #1;
        checks++;
        if (bus.rx_done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_word !== 32'h0 || bus.out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_ack got rx_done=%b valid=%b busy=%b word=%h count=%0d, expected all 0",
                     bus.rx_done, bus.out_valid, bus.busy, bus.out_word, bus.out_count);
        end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        pop(8'h77);
        exp_q.push_back('{word: 32'h0000_0077, count: 4'd1});
        pulse_flush();
        wait_drain();
    endtask

    task automatic test_full_pack();
        bus.out_ready = 1'b1;
        pop(8'h11); pop(8'h22); pop(8'h33);
        exp_q.push_back('{word: 32'h4433_2211, count: 4'd4});
        offer(8'h44);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pack_valid_edge got out_valid=%b, expected 1", bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pack_valid_one_cycle got out_valid=%b, expected 0", bus.out_valid);
        end
        release_rx();
        wait_drain();
    endtask

    task automatic test_backpressure();
        bit stall_bad = 1'b0;
        bus.out_ready = 1'b0;
        pop(8'hA0); pop(8'hA1); pop(8'hA2);
        exp_q.push_back('{word: 32'hA3A2_A1A0, count: 4'd4});
        pop(8'hA3);
        pop(8'hB0); pop(8'hB1); pop(8'hB2);
        exp_q.push_back('{word: 32'hB3B2_B1B0, count: 4'd4});
        bus.in_data = 8'hB3;
        bus.rx_rdy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rx_done !== 1'b0) stall_bad = 1'b1;
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL bp_stall got rx_done=1 during stall, expected 0");
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hA3A2_A1A0) begin
            errors++;
            $display("FAIL bp_hold got valid=%b word=%h, expected valid=1 word=a3a2a1a0",
                     bus.out_valid, bus.out_word);
        end
        bus.out_ready = 1'b1;
        offer(8'hB3);
        release_rx();
        wait_drain();
    endtask

    task automatic test_flush();
        bit seen_valid = 1'b0;
        bus.out_ready = 1'b1;
        pop(8'hA5); pop(8'h5A);
        exp_q.push_back('{word: 32'h0000_5AA5, count: 4'd2});
        pulse_flush();
        wait_drain();
        pulse_flush();
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty got valid_seen=%b busy=%b, expected 0 0", seen_valid, bus.busy);
        end
    endtask

    task automatic test_flush_vs_rx();
        bus.out_ready = 1'b1;
        pop(8'hC1); pop(8'hC2); pop(8'hC3);
        exp_q.push_back('{word: 32'h00C3_C2C1, count: 4'd3});
        exp_q.push_back('{word: 32'h0000_00C4, count: 4'd1});
        bus.flush = 1'b1;
        step();
        bus.flush   = 1'b0;
        bus.in_data = 8'hC4;
        bus.rx_rdy  = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 4'd3 || bus.rx_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority got valid=%b count=%0d rx_done=%b, expected 1 3 0",
                     bus.out_valid, bus.out_count, bus.rx_done);
        end
        offer(8'hC4);
        release_rx();
        pulse_flush();
        wait_drain();
    endtask

`ifdef LIFO_DRAIN_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] vals [2];
        logic             par  [2];
        vals[0] = 8'h01; par[0] = 1'b1;
        vals[1] = 8'h03; par[1] = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            pop(vals[k]);
            exp_q.push_back('{word: {24'h0, vals[k]}, count: 4'd1});
            pulse_flush();
            while (bus.out_valid !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_parity !== par[k]) begin
                errors++;
                $display("FAIL parity word=%h got valid=%b parity=%b, expected 1 %b",
                         bus.out_word, bus.out_valid, bus.out_parity, par[k]);
            end
            wait_drain();
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_pack();
        test_backpressure();
        test_flush();
        test_flush_vs_rx();
`ifdef LIFO_DRAIN_PARITY_EN
        test_parity();
`endif
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
